// File: rtl/sequence_player_if.sv
// Handshake and button-level bundle for sequence_player.
// The z/pass/fail response-checker signals exist only when CHECK_EN is defined.
interface sequence_player_if;
    logic start;
    logic abort;
    logic p1;
    logic p2;
    logic busy;
    logic done;
`ifdef CHECK_EN
    logic z;
    logic pass;
    logic fail;
`endif

`ifdef CHECK_EN
    modport master (
        output start, abort, z,
        input  p1, p2, busy, done, pass, fail
    );
    modport slave (
        input  start, abort, z,
        output p1, p2, busy, done, pass, fail
    );
`else
    modport master (
        output start, abort,
        input  p1, p2, busy, done
    );
    modport slave (
        input  start, abort,
        output p1, p2, busy, done
    );
`endif
endinterface

// File: rtl/sequence_player.sv
// Plays the four-press button code p1,p1,p2,p1 with HOLD-cycle presses and GAP-cycle gaps.
// Define CHECK_EN to add the z response checker with pass/fail pulses at completion.
//
// state | meaning
// IDLE  | waiting for start (abort has priority)
// PRESS | button selected by step held high, counter runs HOLD-1..0
// GAP   | both buttons low, counter runs GAP-1..0
// DONE  | one-cycle completion, done pulse
module sequence_player #(
    parameter int HOLD = 8,
    parameter int GAP  = 4
) (
    input logic            clk,
    input logic            reset,
    sequence_player_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    state_t     state, state_nxt;
    logic [1:0] step, step_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       p1_q, p2_q, busy_q, done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            step  <= 2'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = ST_PRESS;
                    step_nxt  = 2'd0;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            ST_PRESS: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = 2'd0;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'd0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                    step_nxt  = 2'd0;
                    cnt_nxt   = 8'd0;
                end else if (cnt == 8'd0) begin
                    if (step == 2'd3) begin
                        state_nxt = ST_DONE;
                        step_nxt  = 2'd0;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = ST_PRESS;
                        step_nxt  = step + 2'd1;
                        cnt_nxt   = HOLD_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                step_nxt  = 2'd0;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = ST_IDLE;
                step_nxt  = 2'd0;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q   <= 1'b0;
            p2_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            p1_q   <= (state_nxt == ST_PRESS) && (step_nxt != 2'd2);
            p2_q   <= (state_nxt == ST_PRESS) && (step_nxt == 2'd2);
            busy_q <= (state_nxt == ST_PRESS) || (state_nxt == ST_GAP);
            done_q <= (state_nxt == ST_DONE);
        end
    end

    assign bus.p1   = p1_q;
    assign bus.p2   = p2_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

`ifdef CHECK_EN
    logic seen, seen_nxt;
    logic pass_q, fail_q;

    always_comb begin
        seen_nxt = seen;
        if (state == ST_GAP && state_nxt == ST_PRESS && step_nxt == 2'd3)
            seen_nxt = 1'b0;
        else if ((state == ST_PRESS || state == ST_GAP) && step == 2'd3 && bus.z)
            seen_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen   <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            seen   <= seen_nxt;
            pass_q <= (state_nxt == ST_DONE) && seen_nxt;
            fail_q <= (state_nxt == ST_DONE) && !seen_nxt;
        end
    end

    assign bus.pass = pass_q;
    assign bus.fail = fail_q;
`endif

endmodule

// File: tb/tb_sequence_player.sv
// Directed self-checking bench for sequence_player (HOLD=8/GAP=4 and HOLD=1/GAP=1 instances).
// Checker scenarios run when CHECK_EN is defined.
module tb_sequence_player;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    sequence_player_if bus_a ();
    sequence_player_if bus_b ();

    sequence_player #(.HOLD(8), .GAP(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sequence_player #(.HOLD(1), .GAP(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {p1,p2,busy,done} for cycle c after a start sampled at the end of cycle 0, HOLD=8 GAP=4.
    function automatic logic [3:0] exp_a(int c);
        logic p1, p2, busy, done;
        p1   = (c >= 1 && c <= 8) || (c >= 13 && c <= 20) || (c >= 37 && c <= 44);
        p2   = (c >= 25 && c <= 32);
        busy = (c >= 1 && c <= 48);
        done = (c == 49);
        return {p1, p2, busy, done};
    endfunction

    // Same for HOLD=1 GAP=1.
    function automatic logic [3:0] exp_b(int c);
        logic p1, p2, busy, done;
        p1   = (c == 1) || (c == 3) || (c == 7);
        p2   = (c == 5);
        busy = (c >= 1 && c <= 8);
        done = (c == 9);
        return {p1, p2, busy, done};
    endfunction

    task automatic idle_inputs();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
`ifdef CHECK_EN
        bus_a.z = 1'b0;
        bus_b.z = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a outs=%b expected=0000", got);
        end
        got = {bus_b.p1, bus_b.p2, bus_b.busy, bus_b.done};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b outs=%b expected=0000", got);
        end
`ifdef CHECK_EN
        checks++;
        if ({bus_a.pass, bus_a.fail} !== 2'b00) begin
            errors++;
            $display("FAIL reset_passfail got=%b expected=00", {bus_a.pass, bus_a.fail});
        end
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_sequence();
        logic [3:0] got;
        int busy_cycles = 0;
        bus_a.start = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            if (bus_a.busy === 1'b1) busy_cycles++;
            checks++;
            if (got !== exp_a(c)) begin
                errors++;
                $display("FAIL full c=%0d outs=%b expected=%b", c, got, exp_a(c));
            end
        end
        checks++;
        if (busy_cycles != 48) begin
            errors++;
            $display("FAIL full_busy_len got=%0d expected=48", busy_cycles);
        end
    endtask

    task automatic test_abort();
        logic [3:0] got, exp;
        bus_a.start = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            if (c <= 15)      exp = exp_a(c);
            else if (c <= 20) exp = 4'b0000;
            else              exp = exp_a(c - 20);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort c=%0d outs=%b expected=%b", c, got, exp);
            end
            bus_a.start = (c == 20);
            bus_a.abort = (c == 15);
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
    endtask

    task automatic test_idle_conflict();
        logic [3:0] got;
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL idle_conflict c=%0d outs=%b expected=0000", c, got);
            end
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        int both_high = 0;
        bus_a.start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            if (bus_a.p1 === 1'b1 && bus_a.p2 === 1'b1) both_high++;
            exp = (c <= 50) ? exp_a(c) : exp_a(c - 50);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back c=%0d outs=%b expected=%b", c, got, exp);
            end
        end
        bus_a.start = 1'b0;
        checks++;
        if (both_high != 0) begin
            errors++;
            $display("FAIL b2b_exclusive both_high_cycles=%0d expected=0", both_high);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        bus_a.start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        checks++;
        if (bus_a.p2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre p2=%b expected=1", bus_a.p2);
        end
        #2 reset = 1'b1;
        #1;
        got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async outs=%b expected=0000", got);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_quiet c=%0d outs=%b expected=0000", c, got);
            end
        end
        bus_a.start = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            got = {bus_a.p1, bus_a.p2, bus_a.busy, bus_a.done};
            checks++;
            if (got !== exp_a(c)) begin
                errors++;
                $display("FAIL reset_restart c=%0d outs=%b expected=%b", c, got, exp_a(c));
            end
        end
    endtask

    task automatic test_short();
        logic [3:0] got;
        bus_b.start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            got = {bus_b.p1, bus_b.p2, bus_b.busy, bus_b.done};
            checks++;
            if (got !== exp_b(c)) begin
                errors++;
                $display("FAIL short c=%0d outs=%b expected=%b", c, got, exp_b(c));
            end
        end
    endtask

`ifdef CHECK_EN
    task automatic test_checker();
        int         z_cycle [4] = '{46, -1, 30, 37};
        logic [1:0] want    [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
        logic [1:0] got, exp;
        for (int s = 0; s < 4; s++) begin
            bus_a.start = 1'b1;
            for (int c = 1; c <= 52; c++) begin
                @(negedge clk);
                bus_a.start = 1'b0;
                got = {bus_a.pass, bus_a.fail};
                exp = (c == 49) ? want[s] : 2'b00;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL checker s=%0d c=%0d passfail=%b expected=%b", s, c, got, exp);
                end
                bus_a.z = (c == z_cycle[s]);
            end
            bus_a.z = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_sequence();
        test_abort();
        test_idle_conflict();
        test_back_to_back();
        test_reset_mid();
        test_short();
`ifdef CHECK_EN
        test_checker();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
